code_entry_engine: RTL and testbench
====================================

Name: code_entry_engine

Overview:
Datapath sequencer for the keypad lock. It collects digit keypresses into an entry buffer and compares the entry against the master passcode or the stored user code. It also validates and commits a new user code. The top-level lock controller drives it through a single command handshake. Comparison is serial, one digit per cycle, through one shared digit comparator, so latency is fixed.

Parameters:
CODE_LEN, 4, digits per code (2..8)
MASTER_CODE, 16'h1234, master passcode, 4*CODE_LEN bits, digit 0 in the MS nibble

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rdy  in  1  one-cycle strobe; keypress is valid
keypress  in  4  key code; 7/8/9 are command keys, all other values are digits
clear  in  1  flush the entry buffer; abort any command in progress
cmd_valid  in  1  command request
cmd  in  2  0=CMP_PC, 1=CMP_UC, 2=VALIDATE_UC, 3=COMMIT_UC
cmd_ready  out  1  high in IDLE only
done  out  1  one-cycle pulse when a command completes
result  out  1  command outcome; valid with done, held until the next done
uc_set  out  1  a user code has been committed
digit_count  out  4  digits held, saturates at CODE_LEN
overflow  out  1  more than CODE_LEN digits entered since the last flush

Behaviour:
- Reset: the FSM goes to IDLE. All outputs are 0. The entry buffer, candidate register and user code register clear to 0.
- Digit capture happens only in IDLE, on rdy with keypress not in {7,8,9}.
  - The digit shifts into the buffer LS nibble.
  - digit_count increments, saturating at CODE_LEN.
  - A digit arriving at CODE_LEN sets overflow; the buffer keeps its first CODE_LEN digits.
- Keys 7/8/9 never enter the buffer.
- Digits arriving while not in IDLE are dropped.
- Handshake: a command is accepted when cmd_valid & cmd_ready, in cycle t.
  - If a digit strobe arrives in the same cycle t, the digit is captured first and is included in the command.
  - cmd_valid while busy is ignored, not queued.
- FSM states:
  - IDLE: accept command.
    - CMP_PC, CMP_UC and VALIDATE_UC go to CMP.
    - COMMIT_UC goes to COMMIT.
  - CMP: index counter runs 0..CODE_LEN-1. Each cycle compares buffer digit[idx] against the reference digit[idx] and ANDs the outcome into an eq flag. There is no early exit. After the last index, go to FIN.
    - The reference is MASTER_CODE for CMP_PC and VALIDATE_UC.
    - The reference is the user code for CMP_UC.
  - FIN: done=1, result set per command. Flush the buffer (count=0, overflow=0). Go to IDLE.
  - COMMIT: user code <= candidate, uc_set <= 1 if a candidate is pending, else no change. done=1. result = candidate pending. Go to IDLE.
- Latency:
  - Compare-class commands: done at t+CODE_LEN+1.
  - COMMIT_UC: done at t+1.
- Result rules:
  - CMP_PC: result = eq & (count==CODE_LEN) & !overflow.
  - CMP_UC: same as CMP_PC, additionally requiring uc_set. With uc_set=0 the result is 0 regardless of the entry.
  - VALIDATE_UC: result = (count==CODE_LEN) & !overflow & !eq, i.e. the entry must not equal the master code.
    - On result=1, the buffer is copied to the candidate register and candidate pending is set.
    - On result=0, candidate pending is cleared.
  - COMMIT_UC: clears candidate pending.
- A flush (FIN, or clear) zeroes the buffer contents.
- clear:
  - In IDLE: flush only, no done.
  - In CMP: abort with done=1, result=0 in the next cycle, then IDLE. The buffer is flushed. Candidate and user code are unchanged.
  - clear in the same cycle as command acceptance: the command is accepted and then aborted.
- Reset asserted mid-command: immediate return to reset values. No done pulse.

Decomposition:
- Package keylock_pkg holds:
  - cmd encodings (CMD_CMP_PC, CMD_CMP_UC, CMD_VALIDATE_UC, CMD_COMMIT_UC);
  - key constants (KEY_CANCEL=7, KEY_REPRO=8, KEY_LOCK=9);
  - the FSM state enum (IDLE, CMP, FIN, COMMIT);
  - a digit-width constant of 4.
- One sub-module, entry_buffer, holds the shift register, saturating count, overflow flag, flush input and indexed digit read port.
- The FSM, index counter, comparator and code registers stay in code_entry_engine.

Test Plan:
All scenarios use CODE_LEN=4 and MASTER_CODE=16'h1234.
- Digits 1,2,3,4 then CMP_PC at cycle t -> done at t+5, result=1, digit_count=0 afterwards.
- Digits 1,2,3 then CMP_PC -> result=0. Digits 1,2,3,4,5 (overflow=1) then CMP_PC -> result=0.
- Immediately after reset: digits 0,0,0,0 then CMP_UC -> result=0, uc_set=0.
- Validation and commit sequence:
  - Digits 5,6,0,1 then VALIDATE_UC -> result=1.
  - COMMIT_UC -> done at t+1, result=1, uc_set=1.
  - Digits 5,6,0,1 then CMP_UC -> result=1.
  - Digits 1,2,3,4 then VALIDATE_UC -> result=0; a following COMMIT_UC -> result=0.
- Digits 1,8,2,9,3,7,4 with cmd_valid held off -> digit_count=4. A digit strobed during CMP is dropped. CMP_PC -> result=1.
- clear at t+2 of a CMP_PC -> done with result=0 at t+3, buffer empty. reset at t+2 of another compare -> no done, all outputs 0, uc_set=0.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared encodings for the keypad lock: command codes, command keys,
// the code-entry FSM states and the digit width.
package keylock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] CMD_CMP_PC      = 2'd0;
  localparam logic [1:0] CMD_CMP_UC      = 2'd1;
  localparam logic [1:0] CMD_VALIDATE_UC = 2'd2;
  localparam logic [1:0] CMD_COMMIT_UC   = 2'd3;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_REPRO  = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMP    = 2'd1,
    FIN    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic is_digit_key(input logic [3:0] key);
    return !((key == KEY_CANCEL) || (key == KEY_REPRO) || (key == KEY_LOCK));
  endfunction

endpackage

// File: rtl/entry_buffer.sv
// Digit entry buffer: left-shifting nibble register with saturating count,
// overflow flag, flush and an indexed digit read port (digit 0 = oldest).
module entry_buffer
  import keylock_pkg::*;
#(
  parameter int CODE_LEN = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [3:0]                    digit,
  input  logic                          flush,
  input  logic [2:0]                    rd_idx,
  output logic [3:0]                    rd_digit,
  output logic [DIGIT_W*CODE_LEN-1:0]   contents,
  output logic [3:0]                    count,
  output logic                          overflow
);

  localparam int         BUF_W      = DIGIT_W * CODE_LEN;
  localparam logic [3:0] COUNT_FULL = 4'(CODE_LEN);
  localparam logic [2:0] LAST_IDX   = 3'(CODE_LEN - 1);

  logic [BUF_W-1:0] entry_q, entry_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       rd_rev_s;
  logic [BUF_W-1:0] rd_shift_s;

  // Next-state logic: flush wins over push; a push into a full buffer only flags overflow.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      entry_d = '0;
      count_d = 4'd0;
      ovf_d   = 1'b0;
    end else if (push) begin
      if (count_q == COUNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        entry_d = {entry_q[BUF_W-DIGIT_W-1:0], digit};
        count_d = count_q + 4'd1;
      end
    end else begin
      entry_d = entry_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_rev_s   = LAST_IDX - rd_idx;
  assign rd_shift_s = entry_q >> {rd_rev_s, 2'b00};
  assign rd_digit   = rd_shift_s[DIGIT_W-1:0];
  assign contents   = entry_q;
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule

// File: rtl/code_entry_engine.sv
// Keypad-lock code engine: captures digits, serially compares the entry
// against the master or user code, and validates/commits a new user code.
module code_entry_engine
  import keylock_pkg::*;
#(
  parameter int                     CODE_LEN    = 4,
  parameter logic [4*CODE_LEN-1:0]  MASTER_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic [3:0] keypress,
  input  logic       clear,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  output logic       done,
  output logic       result,
  output logic       uc_set,
  output logic [3:0] digit_count,
  output logic       overflow
);

  localparam int         BUF_W      = DIGIT_W * CODE_LEN;
  localparam logic [3:0] COUNT_FULL = 4'(CODE_LEN);
  localparam logic [2:0] LAST_IDX   = 3'(CODE_LEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             eq_q, eq_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [BUF_W-1:0] cand_q, cand_d;
  logic             cand_pend_q, cand_pend_d;
  logic [BUF_W-1:0] uc_q, uc_d;
  logic             uc_set_q, uc_set_d;
  logic             done_q, done_d;
  logic             result_q, result_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             push_s, flush_s, accept_s;
  logic [3:0]       buf_digit_s, ref_digit_s;
  logic [BUF_W-1:0] contents_s, ref_code_s, ref_shift_s;
  logic [2:0]       ref_rev_s;
  logic             eq_fin_s, full_ok_s, valid_uc_s;

  assign push_s   = rdy & is_digit_key(keypress) & (state_q == IDLE);
  assign flush_s  = clear | (state_q == FIN);
  assign accept_s = cmd_valid & cmd_ready_q & (state_q == IDLE);

  entry_buffer #(.CODE_LEN(CODE_LEN)) u_entry (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .digit    (keypress),
    .flush    (flush_s),
    .rd_idx   (idx_q),
    .rd_digit (buf_digit_s),
    .contents (contents_s),
    .count    (digit_count),
    .overflow (overflow)
  );

  // The single digit comparator is shared by every compare-class command.
  assign ref_code_s  = (cmd_q == CMD_CMP_UC) ? uc_q : MASTER_CODE;
  assign ref_rev_s   = LAST_IDX - idx_q;
  assign ref_shift_s = ref_code_s >> {ref_rev_s, 2'b00};
  assign ref_digit_s = ref_shift_s[DIGIT_W-1:0];
  assign eq_fin_s    = eq_q & (buf_digit_s == ref_digit_s);
  assign full_ok_s   = (digit_count == COUNT_FULL) & ~overflow;
  assign valid_uc_s  = full_ok_s & ~eq_fin_s;

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    eq_d        = eq_q;
    cmd_d       = cmd_q;
    cand_d      = cand_q;
    cand_pend_d = cand_pend_q;
    uc_d        = uc_q;
    uc_set_d    = uc_set_q;
    done_d      = 1'b0;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          cmd_d = cmd;
          idx_d = 3'd0;
          eq_d  = 1'b1;
          if (clear) begin
            done_d   = 1'b1;
            result_d = 1'b0;
            state_d  = IDLE;
          end else if (cmd == CMD_COMMIT_UC) begin
            // Commit completes in one cycle; COMMIT only returns to IDLE.
            done_d      = 1'b1;
            result_d    = cand_pend_q;
            cand_pend_d = 1'b0;
            state_d     = COMMIT;
            if (cand_pend_q) begin
              uc_d     = cand_q;
              uc_set_d = 1'b1;
            end else begin
              uc_d = uc_q;
            end
          end else begin
            state_d = CMP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (clear) begin
          done_d   = 1'b1;
          result_d = 1'b0;
          state_d  = IDLE;
        end else if (idx_q == LAST_IDX) begin
          eq_d    = eq_fin_s;
          done_d  = 1'b1;
          state_d = FIN;
          case (cmd_q)
            CMD_CMP_PC: result_d = eq_fin_s & full_ok_s;
            CMD_CMP_UC: result_d = eq_fin_s & full_ok_s & uc_set_q;
            CMD_VALIDATE_UC: begin
              result_d    = valid_uc_s;
              cand_pend_d = valid_uc_s;
              if (valid_uc_s) begin
                cand_d = contents_s;
              end else begin
                cand_d = cand_q;
              end
            end
            default: result_d = 1'b0;
          endcase
        end else begin
          eq_d  = eq_fin_s;
          idx_d = idx_q + 3'd1;
        end
      end
      FIN:     state_d = IDLE;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      eq_q        <= 1'b0;
      cmd_q       <= 2'd0;
      cand_q      <= '0;
      cand_pend_q <= 1'b0;
      uc_q        <= '0;
      uc_set_q    <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      eq_q        <= eq_d;
      cmd_q       <= cmd_d;
      cand_q      <= cand_d;
      cand_pend_q <= cand_pend_d;
      uc_q        <= uc_d;
      uc_set_q    <= uc_set_d;
      done_q      <= done_d;
      result_q    <= result_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign uc_set    = uc_set_q;

endmodule

// File: tb/tb_code_entry_engine.sv
// Scoreboard bench for code_entry_engine (CODE_LEN=4, MASTER_CODE=16'h1234).
module tb_code_entry_engine;

  logic       clk = 1'b0;
  logic       reset, rdy, clear, cmd_valid;
  logic [3:0] keypress;
  logic [1:0] cmd;
  logic       cmd_ready, done, result, uc_set, overflow;
  logic [3:0] digit_count;

  code_entry_engine #(.CODE_LEN(4), .MASTER_CODE(16'h1234)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .keypress(keypress), .clear(clear),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .done(done),
    .result(result), .uc_set(uc_set), .digit_count(digit_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic res;
    int   at;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic press(input logic [3:0] k);
    rdy = 1'b1;
    keypress = k;
    tick();
    rdy = 1'b0;
  endtask

  // seq holds n keys, first key in the most significant used nibble
  task automatic enter(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) press(seq[(n-1-i)*4 +: 4]);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) tick();
    chk("cmd_ready_before_issue", int'(cmd_ready), 1);
  endtask

  task automatic issue(input logic [1:0] c, input logic exp_res, input int lat,
                       input bit track, input bit with_dig, input logic [3:0] dig);
    wait_ready();
    cmd_valid = 1'b1;
    cmd = c;
    if (with_dig) begin
      rdy = 1'b1;
      keypress = dig;
    end
    if (track) sb.push_back('{exp_res, cyc + lat});
    tick();
    cmd_valid = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; clear = 1'b0; cmd_valid = 1'b0;
    keypress = 4'd0; cmd = 2'd0;

    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_done: done=1 with no command outstanding (cycle %0d)", cyc);
            end else begin
              e = sb.pop_front();
              chk("done_cycle", cyc, e.at);
              chk("result", int'(result), int'(e.res));
            end
          end
        end
      end
    join_none

    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_uc_set", int'(uc_set), 0);
    chk("rst_digit_count", int'(digit_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    repeat (2) tick();

    // user-code compare with no user code committed
    enter(32'h0000, 4);
    issue(2'd1, 1'b0, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    chk("uc_set_initial", int'(uc_set), 0);

    // master code match, then flushed buffer
    enter(32'h1234, 4);
    issue(2'd0, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    chk("count_after_fin", int'(digit_count), 0);
    chk("ovf_after_fin", int'(overflow), 0);

    enter(32'h123, 3);
    issue(2'd0, 1'b0, 5, 1'b1, 1'b0, 4'd0);
    wait_done();

    enter(32'h12345, 5);
    chk("ovf_set", int'(overflow), 1);
    chk("count_saturates", int'(digit_count), 4);
    issue(2'd0, 1'b0, 5, 1'b1, 1'b0, 4'd0);
    wait_done();

    // validate, commit and use a user code
    enter(32'h5601, 4);
    issue(2'd2, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    issue(2'd3, 1'b1, 1, 1'b1, 1'b0, 4'd0);
    wait_done();
    chk("uc_set_after_commit", int'(uc_set), 1);
    enter(32'h5601, 4);
    issue(2'd1, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    enter(32'h1234, 4);
    issue(2'd1, 1'b0, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    enter(32'h1234, 4);
    issue(2'd2, 1'b0, 5, 1'b1, 1'b0, 4'd0);
    wait_done();
    issue(2'd3, 1'b0, 1, 1'b1, 1'b0, 4'd0);
    wait_done();
    chk("uc_set_held", int'(uc_set), 1);
    enter(32'h5601, 4);
    issue(2'd1, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    wait_done();

    // command keys filtered; digit and command during CMP are dropped
    enter(32'h1829374, 7);
    chk("count_cmd_keys", int'(digit_count), 4);
    issue(2'd0, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    rdy = 1'b1; keypress = 4'd5; cmd_valid = 1'b1; cmd = 2'd3;
    tick();
    rdy = 1'b0; cmd_valid = 1'b0;
    wait_done();

    // digit strobed in the acceptance cycle is part of the command
    enter(32'h123, 3);
    issue(2'd0, 1'b1, 5, 1'b1, 1'b1, 4'd4);
    wait_done();

    // clear two cycles into a compare aborts it
    enter(32'h1234, 4);
    issue(2'd0, 1'b0, 3, 1'b1, 1'b0, 4'd0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_done();
    chk("count_after_abort", int'(digit_count), 0);

    // clear in IDLE flushes the partial entry
    enter(32'h12, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("count_after_idle_clear", int'(digit_count), 0);
    enter(32'h1234, 4);
    issue(2'd0, 1'b1, 5, 1'b1, 1'b0, 4'd0);
    wait_done();

    // reset in the middle of a compare
    enter(32'h1234, 4);
    issue(2'd0, 1'b1, 5, 1'b0, 1'b0, 4'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_uc_set", int'(uc_set), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 0);
    chk("midrst_count", int'(digit_count), 0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("post_rst_uc_set", int'(uc_set), 0);
    chk("post_rst_count", int'(digit_count), 0);
    chk("post_rst_ready", int'(cmd_ready), 1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
